tx_link_train_seq: RTL

//  Transmit-side link training sequencer; the far-end partner of the RX IOD clock-training / bit-alignment path.

---
 rtl/tx_train_pkg.sv | 43 ++++
 rtl/prbs7_par8.sv | 41 ++++
 rtl/tx_link_train_seq.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/tx_train_pkg.sv
// rtl/tx_train_pkg.sv - shared types and PRBS7 helpers for the TX link training sequencer
// Purpose: state encoding, PRBS7 seed/taps and an 8-bit-per-cycle PRBS7 step function
//          shared by the sequencer and its parallel PRBS generator.
// Ports:   none (package).
package tx_train_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_WAIT_LOCK = 3'd1,
      ST_TRAIN     = 3'd2,
      ST_PRBS      = 3'd3,
      ST_LINK      = 3'd4,
      ST_ERROR     = 3'd5
   } train_state_e;

   // x^7 + x^6 + 1: feedback taps are LFSR bits 6 and 5
   localparam logic [6:0] PRBS7_SEED  = 7'h7F;
   localparam int         PRBS7_TAP_A = 6;
   localparam int         PRBS7_TAP_B = 5;

   typedef struct packed {
      logic [7:0] word;
      logic [6:0] next;
   } prbs7_step_t;

   // Advances the LFSR by eight bits; the first generated bit lands in word[7]
   // because bit 7 is serialized first.
   function automatic prbs7_step_t prbs7_step8(input logic [6:0] state);
      prbs7_step_t res;
      logic [6:0]  st;
      logic        fb;
      st = state;
      res.word = 8'h00;
      for (int i = 0; i < 8; i++) begin
         fb = st[PRBS7_TAP_A] ^ st[PRBS7_TAP_B];
         res.word[7-i] = fb;
         st = {st[5:0], fb};
      end
      res.next = st;
      return res;
   endfunction

endpackage

// File: rtl/prbs7_par8.sv
// rtl/prbs7_par8.sv - PRBS7 generator producing 8 bits per cycle
// Purpose: 7-bit LFSR (x^7+x^6+1, seed 7'h7F) with an 8-bit parallel word, MSB first.
// Ports:   SCLK      - clock
//          RESETN    - asynchronous active-low reset (LFSR returns to seed)
//          load      - reseed; prbs_word shows the first word from the seed this cycle
//          en        - advance the LFSR by 8 bits
//          prbs_word - next 8 PRBS bits (combinational from the current LFSR state)
module prbs7_par8
   import tx_train_pkg::*;
(
   input  logic       SCLK,
   input  logic       RESETN,
   input  logic       load,
   input  logic       en,
   output logic [7:0] prbs_word
);

   logic [6:0]  lfsr_q;
   logic [6:0]  lfsr_d;
   prbs7_step_t step;

   // On load the word is generated from the seed directly so the caller can
   // register it in the same cycle it decides to start a burst.
   always_comb begin
      step      = prbs7_step8(load ? PRBS7_SEED : lfsr_q);
      prbs_word = step.word;
      lfsr_d    = lfsr_q;
      if (load || en) begin
         lfsr_d = step.next;
      end
   end

   always_ff @(posedge SCLK or negedge RESETN) begin
      if (!RESETN) begin
         lfsr_q <= PRBS7_SEED;
      end else begin
         lfsr_q <= lfsr_d;
      end
   end

endmodule

// File: rtl/tx_link_train_seq.sv
// rtl/tx_link_train_seq.sv - transmit-side link training sequencer
// Purpose: drives the TX IOD parallel word through training pattern, PRBS7 qualification
//          burst and user data; retrains on alignment loss, parks in WAIT_LOCK on PLL loss.
// Ports:   SCLK, RESETN (async active-low)     - clock / reset
//          PLL_LOCK, TRAIN_START                - lock status, restart-training pulse
//          RX_ALGN_DONE, RX_PRBS_ERR            - far-end status, asynchronous
//          USR_DATA/USR_VALID/USR_READY         - user payload handshake (LINK only)
//          TXD_DATA                             - registered parallel word to the serializer
//          TRAIN_STATE, LINK_UP, TRAIN_ERR      - status
//          PRBS_ERR_CNT                         - saturating error count of the last burst
module tx_link_train_seq
   import tx_train_pkg::*;
#(
   parameter logic [7:0] TRAIN_PAT     = 8'h55,
   parameter logic [7:0] IDLE_WORD     = 8'h00,
   parameter int         MIN_TRAIN_CYC = 1024,
   parameter int         TIMEOUT_CYC   = 65536,
   parameter int         PRBS_CYC      = 4096,
   parameter int         SYNC_STAGES   = 2
) (
   input  logic        SCLK,
   input  logic        RESETN,
   input  logic        PLL_LOCK,
   input  logic        TRAIN_START,
   input  logic        RX_ALGN_DONE,
   input  logic        RX_PRBS_ERR,
   input  logic [7:0]  USR_DATA,
   input  logic        USR_VALID,
   output logic        USR_READY,
   output logic [7:0]  TXD_DATA,
   output logic [2:0]  TRAIN_STATE,
   output logic        LINK_UP,
   output logic        TRAIN_ERR,
   output logic [15:0] PRBS_ERR_CNT
);

   localparam int CNT_MAX = (TIMEOUT_CYC > PRBS_CYC) ? TIMEOUT_CYC : PRBS_CYC;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   train_state_e           state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [15:0]            err_cnt_q, err_cnt_d, err_inc;
   logic [SYNC_STAGES-1:0] algn_sync_q, algn_sync_d;
   logic [SYNC_STAGES-1:0] err_sync_q, err_sync_d;
   logic [7:0]             txd_q, txd_d;
   logic                   usr_ready_q, usr_ready_d;
   logic                   link_up_q, link_up_d;
   logic                   train_err_q, train_err_d;
   logic                   done_s, err_s;
   logic                   prbs_load, prbs_en;
   logic [7:0]             prbs_word;

   // Synchronizer chains for the far-end status lines
   always_comb begin
      algn_sync_d = {algn_sync_q[SYNC_STAGES-2:0], RX_ALGN_DONE};
      err_sync_d  = {err_sync_q[SYNC_STAGES-2:0], RX_PRBS_ERR};
   end

   assign done_s = algn_sync_q[SYNC_STAGES-1];
   assign err_s  = err_sync_q[SYNC_STAGES-1];

   // State register
   always_ff @(posedge SCLK or negedge RESETN) begin
      if (!RESETN) begin
         state_q <= ST_WAIT_LOCK;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; the end-of-burst decision uses the count including this
   // cycle's error so a last-cycle error still fails qualification.
   always_comb begin
      state_d = state_q;
      err_inc = err_cnt_q;
      if (state_q == ST_PRBS && err_s && err_cnt_q != 16'hFFFF) begin
         err_inc = err_cnt_q + 16'd1;
      end
      if (!PLL_LOCK) begin
         state_d = ST_WAIT_LOCK;
      end else if (TRAIN_START) begin
         state_d = ST_TRAIN;
      end else begin
         case (state_q)
            ST_WAIT_LOCK: state_d = ST_TRAIN;
            ST_TRAIN: begin
               if (cnt_q >= CNT_W'(MIN_TRAIN_CYC - 1) && done_s) begin
                  state_d = ST_PRBS;
               end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                  state_d = ST_ERROR;
               end
            end
            ST_PRBS: begin
               if (!done_s) begin
                  state_d = ST_TRAIN;
               end else if (cnt_q == CNT_W'(PRBS_CYC - 1)) begin
                  state_d = (err_inc == 16'd0) ? ST_LINK : ST_ERROR;
               end
            end
            ST_LINK: begin
               if (!done_s) begin
                  state_d = ST_TRAIN;
               end
            end
            ST_ERROR: state_d = ST_ERROR;
            default:  state_d = ST_WAIT_LOCK;
         endcase
      end
   end

   // Cycle counter runs only while staying in TRAIN or PRBS; any transition
   // (including a TRAIN -> TRAIN restart) clears it.
   always_comb begin
      cnt_d = '0;
      if (state_d == state_q && !TRAIN_START &&
          (state_q == ST_TRAIN || state_q == ST_PRBS)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
      prbs_load = (state_q != ST_PRBS) && (state_d == ST_PRBS);
      prbs_en   = (state_q == ST_PRBS) && (state_d == ST_PRBS);
      err_cnt_d = prbs_load ? 16'd0 : err_inc;
   end

   // Output logic, registered from the next state so the word and flags change
   // together with TRAIN_STATE. A user word is consumed only while READY was shown.
   always_comb begin
      txd_d       = 8'h00;
      usr_ready_d = 1'b0;
      link_up_d   = 1'b0;
      train_err_d = 1'b0;
      case (state_d)
         ST_TRAIN: txd_d = TRAIN_PAT;
         ST_PRBS:  txd_d = prbs_word;
         ST_LINK: begin
            usr_ready_d = 1'b1;
            link_up_d   = 1'b1;
            txd_d       = (usr_ready_q && USR_VALID) ? USR_DATA : IDLE_WORD;
         end
         ST_ERROR: begin
            txd_d       = TRAIN_PAT;
            train_err_d = 1'b1;
         end
         default: txd_d = 8'h00;
      endcase
   end

   always_ff @(posedge SCLK or negedge RESETN) begin
      if (!RESETN) begin
         cnt_q       <= '0;
         err_cnt_q   <= 16'd0;
         algn_sync_q <= '0;
         err_sync_q  <= '0;
         txd_q       <= 8'h00;
         usr_ready_q <= 1'b0;
         link_up_q   <= 1'b0;
         train_err_q <= 1'b0;
      end else begin
         cnt_q       <= cnt_d;
         err_cnt_q   <= err_cnt_d;
         algn_sync_q <= algn_sync_d;
         err_sync_q  <= err_sync_d;
         txd_q       <= txd_d;
         usr_ready_q <= usr_ready_d;
         link_up_q   <= link_up_d;
         train_err_q <= train_err_d;
      end
   end

   prbs7_par8 u_prbs (
      .SCLK      (SCLK),
      .RESETN    (RESETN),
      .load      (prbs_load),
      .en        (prbs_en),
      .prbs_word (prbs_word)
   );

   assign TXD_DATA     = txd_q;
   assign USR_READY    = usr_ready_q;
   assign LINK_UP      = link_up_q;
   assign TRAIN_ERR    = train_err_q;
   assign TRAIN_STATE  = state_q;
   assign PRBS_ERR_CNT = err_cnt_q;

endmodule
